alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver.sv | 143 ++++++++++++++
 tb/tb_alu_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// Command/response sequencer around an external combinational ALU (IDLE -> ISSUE -> RESP).
// Optional accumulate mode (cmd_acc input) is enabled with `define ALU_DRIVER_ACCUM_EN.
module alu_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SELW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SELW-1:0]  cmd_op,
`ifdef ALU_DRIVER_ACCUM_EN
    input  logic             cmd_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SELW-1:0]  alu_sel_q, alu_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             accept;
    logic             illegal;
`ifdef ALU_DRIVER_ACCUM_EN
    logic [WIDTH-1:0] last_q, last_d;
`endif

    assign accept  = cmd_valid & cmd_ready_q;
    // The all-ones opcode is the only illegal encoding.
    assign illegal = (cmd_op == {SELW{1'b1}});

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef ALU_DRIVER_ACCUM_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (illegal) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_zero_d  = 1'b1;
                    end else begin
                        state_d   = StIssue;
`ifdef ALU_DRIVER_ACCUM_EN
                        alu_a_d   = cmd_acc ? last_q : cmd_a;
`else
                        alu_a_d   = cmd_a;
`endif
                        alu_b_d   = cmd_b;
                        alu_sel_d = cmd_op;
                    end
                end
            end
            StIssue: begin
                // alu_c has had one full cycle to settle on the registered operands.
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_c;
                rsp_err_d   = 1'b0;
                rsp_zero_d  = (alu_c == '0);
`ifdef ALU_DRIVER_ACCUM_EN
                last_d      = alu_c;
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef ALU_DRIVER_ACCUM_EN
            last_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_DRIVER_ACCUM_EN
            last_q      <= last_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_driver.sv
// Randomized self-checking bench for alu_driver with a behavioural ALU and reference model.
// Accumulate checks run only when ALU_DRIVER_ACCUM_EN is defined.
module tb_alu_driver;

    localparam int unsigned W = 4;
    localparam int unsigned S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [S-1:0] cmd_op;
`ifdef ALU_DRIVER_ACCUM_EN
    logic         cmd_acc;
`endif
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [S-1:0] alu_sel;
    logic [W-1:0] alu_c;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         rsp_zero;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Reference-side expectations for the registered ALU operands and accumulator.
    int unsigned exp_a = 0, exp_b = 0, exp_sel = 0, exp_last = 0;

    always #5 clk = ~clk;

    alu_driver #(.WIDTH(W), .SELW(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
`ifdef ALU_DRIVER_ACCUM_EN
        .cmd_acc   (cmd_acc),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_zero  (rsp_zero)
    );

    function automatic int unsigned ref_alu(input int unsigned a, input int unsigned b,
                                            input int unsigned op);
        int unsigned r;
        case (op)
            0:       r = a + b;
            1:       r = a + (1 << W) - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = a >> b;
            6:       r = a << b;
            default: r = 0;
        endcase
        return r % (1 << W);
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb alu_c = W'(ref_alu(alu_a, alu_b, alu_sel));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check_eq({tag, "_rsp_err"},   32'(rsp_err),   0);
        check_eq({tag, "_rsp_zero"},  32'(rsp_zero),  0);
        check_eq({tag, "_rsp_data"},  32'(rsp_data),  0);
        check_eq({tag, "_alu_a"},     32'(alu_a),     0);
        check_eq({tag, "_alu_b"},     32'(alu_b),     0);
        check_eq({tag, "_alu_sel"},   32'(alu_sel),   0);
    endtask

    // One full transaction: accept, response latency, optional backpressure, handshake.
    task automatic run_cmd(input int unsigned a, input int unsigned b, input int unsigned op,
                           input bit acc, input int unsigned stall);
        int unsigned res;
        bit          err;
        @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_a     = W'(a);
        cmd_b     = W'(b);
        cmd_op    = S'(op);
`ifdef ALU_DRIVER_ACCUM_EN
        cmd_acc   = acc;
`endif
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (op == 7) begin
            res = 0;
            err = 1'b1;
            check_eq("ill_rsp_valid", 32'(rsp_valid), 1);
        end else begin
`ifdef ALU_DRIVER_ACCUM_EN
            exp_a = acc ? exp_last : a;
`else
            exp_a = a;
`endif
            exp_b   = b;
            exp_sel = op;
            check_eq("issue_rsp_valid", 32'(rsp_valid), 0);
            check_eq("issue_cmd_ready", 32'(cmd_ready), 0);
            @(posedge clk);
            #1;
            res      = ref_alu(exp_a, exp_b, exp_sel);
            err      = 1'b0;
            exp_last = res;
            check_eq("rsp_valid", 32'(rsp_valid), 1);
        end
        check_eq("rsp_data", 32'(rsp_data), res);
        check_eq("rsp_err",  32'(rsp_err),  32'(err));
        check_eq("rsp_zero", 32'(rsp_zero), 32'(res == 0));
        check_eq("alu_a",    32'(alu_a),    exp_a);
        check_eq("alu_b",    32'(alu_b),    exp_b);
        check_eq("alu_sel",  32'(alu_sel),  exp_sel);
        for (int i = 0; i < int'(stall); i++) begin
            // Commands offered while a response is pending must be ignored.
            cmd_valid = 1'b1;
            cmd_a     = W'($urandom);
            cmd_b     = W'($urandom);
            cmd_op    = S'($urandom);
            @(posedge clk);
            #1;
            check_eq("bp_rsp_valid", 32'(rsp_valid), 1);
            check_eq("bp_rsp_data",  32'(rsp_data),  res);
            check_eq("bp_rsp_err",   32'(rsp_err),   32'(err));
            check_eq("bp_rsp_zero",  32'(rsp_zero),  32'(res == 0));
            check_eq("bp_cmd_ready", 32'(cmd_ready), 0);
            check_eq("bp_alu_a",     32'(alu_a),     exp_a);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 0);
        check_eq("post_cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
`ifdef ALU_DRIVER_ACCUM_EN
        cmd_acc   = 1'b0;
`endif
        rsp_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_cmd_ready", 32'(cmd_ready), 1);

        run_cmd(7, 5, 0, 1'b0, 0);   // 7+5 = C
        run_cmd(3, 5, 1, 1'b0, 0);   // 3-5 wraps to E
        run_cmd(6, 6, 4, 1'b0, 0);   // xor to zero
        run_cmd(7, 1, 0, 1'b0, 0);
        run_cmd(2, 9, 7, 1'b0, 0);   // illegal, alu_a stays 7
        run_cmd(9, 4, 3, 1'b0, 5);   // five cycles of backpressure
        run_cmd(15, 15, 6, 1'b0, 0);
        run_cmd(8, 3, 5, 1'b0, 0);

`ifdef ALU_DRIVER_ACCUM_EN
        run_cmd(2, 3, 0, 1'b0, 0);
        run_cmd(0, 4, 0, 1'b1, 0);
        check_eq("acc_alu_a", 32'(alu_a), 5);
        check_eq("acc_rsp",   32'(ref_alu(5, 4, 0)), exp_last);
`endif

        for (int n = 0; n < 60; n++) begin
            run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset while in ISSUE: the command is dropped and state is cleared at once.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = 4'd9;
        cmd_b     = 4'd3;
        cmd_op    = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("midop");
        exp_a    = 0;
        exp_b    = 0;
        exp_sel  = 0;
        exp_last = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("midop_no_rsp",    32'(rsp_valid), 0);
            check_eq("midop_cmd_ready", 32'(cmd_ready), 1);
        end
        rsp_ready = 1'b0;
        run_cmd(4, 4, 1, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
